// File: rtl/multi_sensor_slot_pkg.sv
// -----------------------------------------------------------------------------
// multi_sensor_slot_pkg
// Shared definitions for the multi-channel slot encoder:
//   state_e        - FSM state encoding (IDLE, SAMPLE)
//   slot_ch_width  - width of the slot_ch output for a given channel count
//   FRAME_LEN      - frame length in cycles for the default counter widths
// -----------------------------------------------------------------------------
package multi_sensor_slot_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_SLOT_W = 4;
    localparam int unsigned FRAME_LEN  = 2 ** (DEF_SLOT_W + DEF_DATA_W);

    // A single channel still needs a 1-bit index port.
    function automatic int unsigned slot_ch_width(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/multi_sensor_slot_encoder_counter.sv
// -----------------------------------------------------------------------------
// slot_frame_counter
// Slot / data step counters for one encoding frame.
//   clk_division  in   divided sampling clock, rising edge
//   rst           in   asynchronous active-low reset
//   i_en          in   advance counters this cycle
//   i_clr         in   synchronous clear to 0 (dominates i_en)
//   o_slot_cnt    out  slot counter, wraps every 2^SLOT_W cycles
//   o_data_cnt    out  data step counter, advances when slot counter wraps
//   o_frame_last  out  both counters all-ones (last cycle of a frame)
// -----------------------------------------------------------------------------
module slot_frame_counter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SLOT_W = 4
) (
    input  logic              clk_division,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clr,
    output logic [SLOT_W-1:0] o_slot_cnt,
    output logic [DATA_W-1:0] o_data_cnt,
    output logic              o_frame_last
);

    logic [SLOT_W-1:0] r_slot_cnt;
    logic [DATA_W-1:0] r_data_cnt;
    logic              w_slot_last;

    assign w_slot_last = &r_slot_cnt;

    always_ff @(posedge clk_division or negedge rst) begin
        if (!rst) begin
            r_slot_cnt <= '0;
            r_data_cnt <= '0;
        end else if (i_clr) begin
            r_slot_cnt <= '0;
            r_data_cnt <= '0;
        end else if (i_en) begin
            // Natural wrap of both counters returns them to 0 at frame end.
            r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
            if (w_slot_last) begin
                r_data_cnt <= r_data_cnt + DATA_W'(1);
            end
        end
    end

    assign o_slot_cnt   = r_slot_cnt;
    assign o_data_cnt   = r_data_cnt;
    assign o_frame_last = w_slot_last & (&r_data_cnt);

endmodule

// File: rtl/multi_sensor_slot_encoder.sv
// -----------------------------------------------------------------------------
// multi_sensor_slot_encoder
// Latches NUM_CH sensor words and sweeps a frame of 2^SLOT_W slots x 2^DATA_W
// data steps, emitting one pulse per channel on a shared line at that
// channel's slot address in the data step equal to its latched value.
//   clk_division  in   divided sampling clock, rising edge
//   rst           in   asynchronous active-low reset
//   sample_en     in   start request, honoured only in IDLE
//   cont_en       in   continuous mode, sampled at frame end
//   ch_mask       in   per-channel enable (only with SENSOR_CH_MASK_EN)
//   sensor        in   channel i at [i*DATA_W +: DATA_W]
//   slot          out  shared pulse-position line
//   slot_ch       out  channel owning the current pulse, 0 otherwise
//   busy          out  high while sampling a frame
//   frame_done    out  high on the last cycle of each frame
// Optional feature macro: SENSOR_CH_MASK_EN (adds ch_mask, latched with sensor).
// -----------------------------------------------------------------------------
module multi_sensor_slot_encoder
    import multi_sensor_slot_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SLOT_W    = 4,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                               clk_division,
    input  logic                               rst,
    input  logic                               sample_en,
    input  logic                               cont_en,
`ifdef SENSOR_CH_MASK_EN
    input  logic [NUM_CH-1:0]                  ch_mask,
`endif
    input  logic [NUM_CH*DATA_W-1:0]           sensor,
    output logic                               slot,
    output logic [slot_ch_width(NUM_CH)-1:0]   slot_ch,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int unsigned CH_W = slot_ch_width(NUM_CH);

    if (NUM_CH < 1 || BASE_ADDR + NUM_CH > 2 ** SLOT_W) begin : g_param_check
        $error("multi_sensor_slot_encoder: channel slot addresses exceed slot range");
    end

    state_e                         r_state;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_word;
    logic [NUM_CH-1:0]              w_mask;
    logic [SLOT_W-1:0]              w_slot_cnt;
    logic [DATA_W-1:0]              w_data_cnt;
    logic                           w_frame_last;
    logic                           w_sampling;
    logic                           w_slot;
    logic [CH_W-1:0]                w_slot_ch;

    assign w_sampling = (r_state == SAMPLE);

    slot_frame_counter #(
        .DATA_W (DATA_W),
        .SLOT_W (SLOT_W)
    ) u_counter (
        .clk_division (clk_division),
        .rst          (rst),
        .i_en         (w_sampling),
        .i_clr        (!w_sampling),
        .o_slot_cnt   (w_slot_cnt),
        .o_data_cnt   (w_data_cnt),
        .o_frame_last (w_frame_last)
    );

`ifdef SENSOR_CH_MASK_EN
    logic [NUM_CH-1:0] r_mask;

    always_ff @(posedge clk_division or negedge rst) begin
        if (!rst) begin
            r_mask <= '1;
        end else if ((r_state == IDLE && sample_en) ||
                     (w_sampling && w_frame_last && cont_en)) begin
            r_mask <= ch_mask;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = '1;
`endif

    // Words only change at frame start, so a frame never sees a mid-frame update.
    always_ff @(posedge clk_division or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_word  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sample_en) begin
                        r_state <= SAMPLE;
                        r_word  <= sensor;
                    end
                end
                SAMPLE: begin
                    if (w_frame_last) begin
                        if (cont_en) begin
                            r_word <= sensor;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Slot addresses are distinct, so at most one channel can match.
    always_comb begin
        w_slot    = 1'b0;
        w_slot_ch = '0;
        if (w_sampling) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_slot && w_mask[i] &&
                    w_slot_cnt == SLOT_W'(BASE_ADDR + i) &&
                    w_data_cnt == r_word[i]) begin
                    w_slot    = 1'b1;
                    w_slot_ch = CH_W'(i);
                end
            end
        end
    end

    assign slot       = w_slot;
    assign slot_ch    = w_slot_ch;
    assign busy       = w_sampling;
    assign frame_done = w_sampling & w_frame_last;

endmodule

// File: tb/tb_multi_sensor_slot_encoder.sv
module tb_multi_sensor_slot_encoder;
    import multi_sensor_slot_pkg::*;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned SLOT_W    = 4;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned BASE_ADDR = 0;
    localparam int unsigned SLOTS     = 2 ** SLOT_W;
    localparam int unsigned CH_W      = slot_ch_width(NUM_CH);

    typedef struct {
        int unsigned cyc;
        int unsigned ch;
    } evt_t;

    logic                      clk_division = 1'b0;
    logic                      rst          = 1'b0;
    logic                      sample_en    = 1'b0;
    logic                      cont_en      = 1'b0;
    logic [NUM_CH-1:0]         ch_mask      = '1;
    logic [NUM_CH*DATA_W-1:0]  sensor       = '0;
    logic                      slot;
    logic [CH_W-1:0]           slot_ch;
    logic                      busy;
    logic                      frame_done;

    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    evt_t        exp_q[$];
    int unsigned fd_q[$];

    multi_sensor_slot_encoder #(
        .DATA_W    (DATA_W),
        .SLOT_W    (SLOT_W),
        .NUM_CH    (NUM_CH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk_division (clk_division),
        .rst          (rst),
        .sample_en    (sample_en),
        .cont_en      (cont_en),
`ifdef SENSOR_CH_MASK_EN
        .ch_mask      (ch_mask),
`endif
        .sensor       (sensor),
        .slot         (slot),
        .slot_ch      (slot_ch),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk_division = ~clk_division;

    always @(posedge clk_division) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ins(input int unsigned c, input int unsigned ch);
        evt_t e;
        int   idx;
        e.cyc = c;
        e.ch  = ch;
        idx   = exp_q.size();
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k].cyc > c) begin
                idx = k;
                break;
            end
        end
        exp_q.insert(idx, e);
    endfunction

    // Expected pulse of channel i: data step = word, slot = BASE_ADDR + i.
    function automatic void push_frame(input int unsigned start,
                                       input logic [NUM_CH*DATA_W-1:0] s,
                                       input logic [NUM_CH-1:0] m);
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
                ins(start + int'(s[i*DATA_W +: DATA_W]) * SLOTS + BASE_ADDR + i, i);
            end
        end
    endfunction

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk_division);
    endtask

    // Returns the bench cycle number of frame cycle 0.
    task automatic start_frame(input bit keep, output int unsigned start);
        @(negedge clk_division);
        sample_en = 1'b1;
        @(negedge clk_division);
        if (!keep) sample_en = 1'b0;
        start = cyc;
        check("busy at frame start", busy, 1);
    endtask

    // Monitor: compares every pulse and frame_done against the scoreboard.
    always @(negedge clk_division) begin
        if (slot === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected pulse: got pulse ch %0d at cycle %0d, expected none",
                         slot_ch, cyc);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                check("pulse cycle", cyc, e.cyc);
                check("pulse channel", 32'(slot_ch), e.ch);
            end
        end else begin
            check("slot_ch idle", 32'(slot_ch), 0);
        end
        if (frame_done === 1'b1) begin
            if (fd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected frame_done: got 1 at cycle %0d, expected 0", cyc);
            end else begin
                int unsigned f;
                f = fd_q.pop_front();
                check("frame_done cycle", cyc, f);
            end
        end
    end

    initial begin
        int unsigned st;
        logic [NUM_CH*DATA_W-1:0] s_a;
        logic [NUM_CH*DATA_W-1:0] s_b;

        // Reset state
        #3;
        check("reset slot", slot, 0);
        check("reset slot_ch", 32'(slot_ch), 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        repeat (2) @(negedge clk_division);
        rst = 1'b1;
        repeat (3) @(negedge clk_division);
        check("idle busy", busy, 0);

        // Single frame: ch3..ch0 = 3, 0, 255, 17
        sensor = {8'd3, 8'd0, 8'd255, 8'd17};
        start_frame(1'b0, st);
        ins(st + 2, 2);
        ins(st + 51, 3);
        ins(st + 272, 0);
        ins(st + 4081, 1);
        fd_q.push_back(st + 4095);
        wait_until(st + FRAME_LEN);
        check("busy after single frame", busy, 0);

        // Continuous mode, sensor change mid-frame takes effect next frame
        s_a     = {8'd40, 8'd30, 8'd20, 8'd10};
        s_b     = {8'd5, 8'd50, 8'd100, 8'd200};
        sensor  = s_a;
        cont_en = 1'b1;
        start_frame(1'b0, st);
        push_frame(st, s_a, '1);
        push_frame(st + FRAME_LEN, s_b, '1);
        fd_q.push_back(st + FRAME_LEN - 1);
        fd_q.push_back(st + 2 * FRAME_LEN - 1);
        wait_until(st + 1000);
        sensor = s_b;
        wait_until(st + FRAME_LEN);
        check("busy no gap", busy, 1);
        wait_until(st + FRAME_LEN + 100);
        cont_en = 1'b0;
        wait_until(st + 2 * FRAME_LEN);
        check("busy after cont frames", busy, 0);

        // sample_en held through the frame and at frame end, sensor toggling
        sensor = {8'd160, 8'd120, 8'd80, 8'd40};
        start_frame(1'b1, st);
        push_frame(st, sensor, '1);
        fd_q.push_back(st + FRAME_LEN - 1);
        while (cyc < st + FRAME_LEN) begin
            @(negedge clk_division);
            sensor = NUM_CH * DATA_W'($urandom);
        end
        sample_en = 1'b0;
        check("busy after held sample_en", busy, 0);
        repeat (4) @(negedge clk_division);
        check("no restart after dropped request", busy, 0);

        // Asynchronous reset in frame cycle 1000
        sensor = {8'd200, 8'd100, 8'd30, 8'd10};
        start_frame(1'b0, st);
        ins(st + 160, 0);
        ins(st + 481, 1);
        wait_until(st + 999);
        @(posedge clk_division);
        #2;
        rst = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset slot", slot, 0);
        check("async reset frame_done", frame_done, 0);
        repeat (3) @(negedge clk_division);
        rst = 1'b1;
        repeat (5000) @(negedge clk_division);
        check("idle after reset release", busy, 0);

        // Fresh frame after reset starts from zeroed counters
        sensor = {8'd255, 8'd1, 8'd128, 8'd0};
        start_frame(1'b0, st);
        push_frame(st, sensor, '1);
        fd_q.push_back(st + FRAME_LEN - 1);
        wait_until(st + FRAME_LEN);
        check("busy after post-reset frame", busy, 0);

`ifdef SENSOR_CH_MASK_EN
        // Masked channel 1 stays silent
        sensor  = {8'd5, 8'd5, 8'd5, 8'd5};
        ch_mask = 4'b1101;
        start_frame(1'b0, st);
        push_frame(st, sensor, 4'b1101);
        fd_q.push_back(st + FRAME_LEN - 1);
        ch_mask = 4'b1111;
        wait_until(st + FRAME_LEN);
        check("busy after masked frame", busy, 0);
`endif

        repeat (10) @(negedge clk_division);
        check("pulses outstanding", exp_q.size(), 0);
        check("frame_done outstanding", fd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
